// File: rtl/add_seq_ctrl_pkg.sv
// add_seq_ctrl_pkg: shared constants and types for the sequential adder.
//   SLICE_W  width of the single reused adder slice
//   state_e  controller state encoding (IDLE/RUN/DONE; 2'd3 is unused and
//            recovers to IDLE)
// Optional feature macro used by the block: ADD_SEQ_SUB_EN (subtract support).
package add_seq_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add_seq_ctrl_if.sv
// add_seq_ctrl_if: operand request / result response bundle.
//   start_valid/start_ready  operand handshake (producer -> block)
//   a, b, c_in               operands, sampled on the start handshake
//   sub                      subtract select (only with ADD_SEQ_SUB_EN)
//   done_valid/done_ready    result handshake (block -> consumer)
//   sum, c_out               result, stable while done_valid
// Modports: master = producer/consumer side, slave = add_seq_ctrl.
interface add_seq_ctrl_if #(parameter int WORDS = 4);
  import add_seq_ctrl_pkg::*;

  localparam int WIDTH = SLICE_W * WORDS;

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef ADD_SEQ_SUB_EN
  logic             sub;
`endif
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start_valid, a, b, c_in,
`ifdef ADD_SEQ_SUB_EN
    output sub,
`endif
    output done_ready,
    input  start_ready, done_valid, sum, c_out
  );

  modport slave (
    input  start_valid, a, b, c_in,
`ifdef ADD_SEQ_SUB_EN
    input  sub,
`endif
    input  done_ready,
    output start_ready, done_valid, sum, c_out
  );

endinterface

// File: rtl/add_seq_ctrl_slice.sv
// add4_slice: SLICE_W-bit ripple-carry adder, the only arithmetic in the block.
//   a, b   slice operands
//   c_in   carry into bit 0
//   sum    slice sum
//   c_out  carry out of the top bit
module add4_slice
  import add_seq_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  output logic [SLICE_W-1:0] sum,
  output logic               c_out
);

  logic [SLICE_W:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[SLICE_W];

endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: WORDS*4-bit adder built from one 4-bit slice reused over
// WORDS cycles; the inter-slice carry lives in a flop.
//   clk    clock, rising edge
//   rst    synchronous active-high reset (aborts any operation)
//   io     add_seq_ctrl_if.slave: operand handshake in, result handshake out
//   busy   high whenever the controller is not IDLE
// Parameter WORDS (2..16): slices per operand, WIDTH = 4*WORDS.
// Macro ADD_SEQ_SUB_EN: adds io.sub; sub=1 computes A-B by latching ~B with
// carry forced to 1, so c_out=1 means no borrow.
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic          clk,
  input  logic          rst,
  add_seq_ctrl_if.slave io,
  output logic          busy
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef logic [SLICE_W-1:0] nib_t;

  state_e          state;
  logic [IW-1:0]   idx;
  logic            carry;
  nib_t [WORDS-1:0] a_q;
  nib_t [WORDS-1:0] b_q;
  nib_t [WORDS-1:0] sum_q;
  logic            c_out_q;
  logic            start_ready_q;
  logic            done_valid_q;
  logic            busy_q;

  nib_t            slice_s;
  logic            slice_co;

  // Operand mux by idx; the result is demuxed back into sum_q[idx] below.
  add4_slice u_slice (
    .a     (a_q[idx]),
    .b     (b_q[idx]),
    .c_in  (carry),
    .sum   (slice_s),
    .c_out (slice_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      carry         <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      sum_q         <= '0;
      c_out_q       <= 1'b0;
      start_ready_q <= 1'b1;
      done_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io.start_valid) begin
            a_q           <= io.a;
`ifdef ADD_SEQ_SUB_EN
            // Two's complement subtract: A + ~B + 1.
            b_q           <= io.sub ? ~io.b : io.b;
            carry         <= io.sub | io.c_in;
`else
            b_q           <= io.b;
            carry         <= io.c_in;
`endif
            idx           <= '0;
            sum_q         <= '0;
            c_out_q       <= 1'b0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state         <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[idx] <= slice_s;
          carry      <= slice_co;
          if (idx == LAST) begin
            c_out_q      <= slice_co;
            done_valid_q <= 1'b1;
            state        <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          // start_ready rises together with the return to IDLE, so the
          // earliest new accept is the edge after this one.
          if (io.done_ready) begin
            done_valid_q  <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: begin
          done_valid_q  <= 1'b0;
          start_ready_q <= 1'b1;
          busy_q        <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

  assign io.start_ready = start_ready_q;
  assign io.done_valid  = done_valid_q;
  assign io.sum         = sum_q;
  assign io.c_out       = c_out_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: self-checking bench for add_seq_ctrl.
// Main DUT (WORDS=4): reset values, vector table, backpressure, reset
// mid-RUN, random operands. Two extra DUTs (WORDS=2, WORDS=16) run random
// operands against an arithmetic reference model and check latency.
module tb_add_seq_ctrl;

  localparam int W4 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_sw = 1'b1;
  logic busy;
  logic [1:0] sweep_done = 2'b00;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  add_seq_ctrl_if #(.WORDS(W4)) io();

  add_seq_ctrl #(.WORDS(W4)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .io   (io.slave),
    .busy (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_co;
  } vec_t;

  // Launch one operation on the main DUT (waits for start_ready, bounded).
  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub);
    int k = 0;
    while (!io.start_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("start_ready_wait", io.start_ready, 1'b1);
    io.a = a;
    io.b = b;
    io.c_in = cin;
`ifdef ADD_SEQ_SUB_EN
    io.sub = sub;
`else
    if (sub) chk("sub_unsupported", 1'b1, 1'b0);
`endif
    io.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.start_valid = 1'b0;
    // Scramble inputs: the DUT must use its latched copy.
    io.a = 16'($urandom);
    io.b = 16'($urandom);
    io.c_in = 1'($urandom);
  endtask

  // Count edges after the accept edge until done_valid (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!io.done_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic finish_op();
    io.done_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.done_ready = 1'b0;
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, output logic [15:0] s, output logic co,
                       output int lat);
    start_op(a, b, cin, sub);
    wait_done(lat);
    s = io.sum;
    co = io.c_out;
    finish_op();
  endtask

  // Parameter sweep DUTs with their own random loops.
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int W = (g == 0) ? 2 : 16;
    localparam int N = 4 * W;
    logic sbusy;

    add_seq_ctrl_if #(.WORDS(W)) sio();

    add_seq_ctrl #(.WORDS(W)) u_sw (
      .clk  (clk),
      .rst  (rst_sw),
      .io   (sio.slave),
      .busy (sbusy)
    );

    initial begin
      logic [N-1:0] ra, rb, es;
      logic         rc, rs, ec;
      logic [N:0]   full;
      int           k, lat;
      sio.start_valid = 1'b0;
      sio.done_ready  = 1'b0;
      sio.a = '0;
      sio.b = '0;
      sio.c_in = 1'b0;
`ifdef ADD_SEQ_SUB_EN
      sio.sub = 1'b0;
`endif
      k = 0;
      while (rst_sw && k < 100) begin
        @(negedge clk);
        k++;
      end
      @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
        ra = N'({$urandom, $urandom});
        rb = N'({$urandom, $urandom});
        rc = 1'($urandom);
        rs = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        rs = ($urandom_range(0, 3) == 0);
`endif
        if (rs) begin
          es = ra - rb;
          ec = (ra >= rb);
        end else begin
          full = {1'b0, ra} + {1'b0, rb} + (N+1)'(rc);
          es = full[N-1:0];
          ec = full[N];
        end
        k = 0;
        while (!sio.start_ready && k < 50) begin
          @(negedge clk);
          k++;
        end
        chk("sw_start_ready", sio.start_ready, 1'b1);
        sio.a = ra;
        sio.b = rb;
        sio.c_in = rc;
`ifdef ADD_SEQ_SUB_EN
        sio.sub = rs;
`endif
        sio.start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sio.start_valid = 1'b0;
        sio.a = N'({$urandom, $urandom});
        sio.b = N'({$urandom, $urandom});
        lat = 0;
        while (!sio.done_valid && lat < 200) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
        end
        chk($sformatf("sw%0d_lat", W), 64'(lat), 64'(W));
        chk($sformatf("sw%0d_sum", W), 64'(sio.sum), 64'(es));
        chk($sformatf("sw%0d_cout", W), 64'(sio.c_out), 64'(ec));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        sio.done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sio.done_ready = 1'b0;
      end
      sweep_done[g] = 1'b1;
    end
  end

  initial begin
    vec_t        tbl[$];
    logic [15:0] s, s0, ra, rb, es;
    logic        co, c0, rc, rs, ec;
    logic [16:0] full;
    int          lat, k;

    io.start_valid = 1'b0;
    io.done_ready  = 1'b0;
    io.a = '0;
    io.b = '0;
    io.c_in = 1'b0;
`ifdef ADD_SEQ_SUB_EN
    io.sub = 1'b0;
`endif

    tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    tbl.push_back('{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0});
    tbl.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    tbl.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
    tbl.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0});
`ifdef ADD_SEQ_SUB_EN
    tbl.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    tbl.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1});
    tbl.push_back('{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1});
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    rst_sw = 1'b0;

    // Reset values
    chk("rst_start_ready", io.start_ready, 1'b1);
    chk("rst_done_valid", io.done_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", io.sum, 16'h0000);
    chk("rst_cout", io.c_out, 1'b0);

    // Vector table
    foreach (tbl[i]) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, s, co, lat);
      chk($sformatf("vec%0d_sum", i), s, tbl[i].exp_sum);
      chk($sformatf("vec%0d_cout", i), co, tbl[i].exp_co);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(W4));
    end

    // Backpressure: result held, new start ignored
    start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    wait_done(lat);
    chk("bp_lat", 64'(lat), 64'(W4));
    s0 = io.sum;
    c0 = io.c_out;
    chk("bp_sum0", s0, 16'h1000);
    chk("bp_cout0", c0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      io.start_valid = 1'b1;
      io.a = 16'($urandom);
      io.b = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("bp_done_valid", io.done_valid, 1'b1);
      chk("bp_sum_hold", io.sum, s0);
      chk("bp_cout_hold", io.c_out, c0);
      chk("bp_start_ready", io.start_ready, 1'b0);
    end
    io.start_valid = 1'b0;
    finish_op();
    chk("bp_rel_start_ready", io.start_ready, 1'b1);
    chk("bp_rel_done_valid", io.done_valid, 1'b0);
    chk("bp_rel_busy", busy, 1'b0);
    @(negedge clk);
    chk("bp_no_leak_busy", busy, 1'b0);

    // Reset mid-RUN at idx=2
    start_op(16'hFFFF, 16'h0001, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mr_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mr_busy", busy, 1'b0);
    chk("mr_sum", io.sum, 16'h0000);
    chk("mr_cout", io.c_out, 1'b0);
    chk("mr_start_ready", io.start_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mr_no_done", io.done_valid, 1'b0);
    end

    // Random operands vs reference model
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'b0;
`ifdef ADD_SEQ_SUB_EN
      rs = ($urandom_range(0, 3) == 0);
`endif
      if (rs) begin
        es = ra - rb;
        ec = (ra >= rb);
      end else begin
        full = {1'b0, ra} + {1'b0, rb} + 17'(rc);
        es = full[15:0];
        ec = full[16];
      end
      do_op(ra, rb, rc, rs, s, co, lat);
      chk("rnd_sum", s, es);
      chk("rnd_cout", co, ec);
      chk("rnd_lat", 64'(lat), 64'(W4));
    end

    k = 0;
    while (sweep_done != 2'b11 && k < 60000) begin
      @(negedge clk);
      k++;
    end
    chk("sweep_complete", sweep_done, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
